// File: rtl/timer_multi_us.sv
// timer_multi_us: multi-channel microsecond countdown timer with a shared 1 us prescaler
// Ports: clk/reset (sync, active-low); clear (sync idle-all); en (global freeze when 0);
//   start/stop/periodic per channel; load_val packed CNT_W per channel;
//   tick_us 1 us strobe; expired 1-cycle terminal pulse; busy while running; count remaining us.
module timer_multi_us #(
  parameter int CLK_FREQ_MHZ = 12,
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*CNT_W-1:0] load_val,
  output logic                      tick_us,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] count
);
  localparam int PW = CLK_FREQ_MHZ > 1 ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_FREQ_MHZ - 1);
  typedef enum logic {IDLE, RUN} state_t;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tk;
  // with a 1 MHz clock PMAX is 0, so pre stays 0 and tk degenerates to en
  assign tk      = en && pre_q == PMAX;
  assign pre_d   = !en ? pre_q : tk ? '0 : pre_q + PW'(1);
  assign tick_us = tick_q;
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tk;
    end
  end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, rel_q, rel_d, ld;
    logic             mode_q, mode_d, exp_q, exp_d;
    assign ld = load_val[i*CNT_W +: CNT_W];
    // start outranks stop and tick; a zero-length start expires immediately without running
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rel_d  = rel_q;
      mode_d = mode_q;
      exp_d  = 1'b0;
      if (start[i]) begin
        st_d   = |ld ? RUN : IDLE;
        cnt_d  = ld;
        rel_d  = |ld ? ld : rel_q;
        mode_d = |ld ? periodic[i] : mode_q;
        exp_d  = ~|ld;
      end else if (st_q == RUN && stop[i]) begin
        st_d  = IDLE;
        cnt_d = '0;
      end else if (st_q == RUN && tk) begin
        cnt_d = cnt_q > CNT_W'(1) ? cnt_q - CNT_W'(1) : mode_q ? rel_q : '0;
        st_d  = cnt_q > CNT_W'(1) || mode_q ? RUN : IDLE;
        exp_d = cnt_q == CNT_W'(1);
      end
    end
    always_ff @(posedge clk) begin
      if (!reset || clear) begin
        st_q   <= IDLE;
        cnt_q  <= '0;
        rel_q  <= '0;
        mode_q <= 1'b0;
        exp_q  <= 1'b0;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        rel_q  <= rel_d;
        mode_q <= mode_d;
        exp_q  <= exp_d;
      end
    end
    assign expired[i]                 = exp_q;
    assign busy[i]                    = st_q == RUN;
    assign count[i*CNT_W +: CNT_W]    = cnt_q;
  end
endmodule

// File: tb/tb_timer_multi_us.sv
// tb_timer_multi_us: directed self-checking bench for timer_multi_us
module tb_timer_multi_us;
  localparam int CH = 4, W = 16, F = 12;
  logic clk = 1'b0, reset = 1'b0, clear = 1'b0, en = 1'b0;
  logic [CH-1:0] start = '0, stop = '0, periodic = '0;
  logic [CH*W-1:0] load_val = '0;
  logic tick_us;
  logic [CH-1:0] expired, busy;
  logic [CH*W-1:0] count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  timer_multi_us #(.CLK_FREQ_MHZ(F), .CHANNELS(CH), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .start(start), .stop(stop),
    .periodic(periodic), .load_val(load_val), .tick_us(tick_us), .expired(expired),
    .busy(busy), .count(count)
  );
  function automatic logic [W-1:0] cnt(int c);
    return count[c*W +: W];
  endfunction
  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_tick(output int n);
    n = 0;
    for (int k = 1; k <= 4*F && n == 0; k++) begin
      cyc();
      if (tick_us) n = k;
    end
  endtask
  task automatic wait_exp(input int c, input int lim, output int n);
    n = 0;
    for (int k = 1; k <= lim && n == 0; k++) begin
      cyc();
      if (expired[c]) n = k;
    end
  endtask
  task automatic test_reset;
    int n;
    reset = 1'b0;
    cyc(3);
    checks++; if (tick_us !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", tick_us); end
    checks++; if (expired !== '0) begin errors++; $display("FAIL rst_expired got %b want 0", expired); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got %h want 0", count); end
    reset = 1'b1;
    en = 1'b1;
    wait_tick(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL first_tick got %0d want 12", n); end
    wait_tick(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL tick_period got %0d want 12", n); end
    checks++; if (expired !== '0) begin errors++; $display("FAIL idle_expired got %b want 0", expired); end
  endtask
  task automatic test_oneshot;
    int n;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++; if (busy !== '0 || tick_us !== 1'b0) begin errors++; $display("FAIL clear_state got busy=%b tick=%b want 0", busy, tick_us); end
    wait_tick(n);
    cyc(11);
    load_val[0*W +: W] = 16'd5;
    periodic[0] = 1'b0;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    checks++; if (busy[0] !== 1'b1 || cnt(0) !== 16'd5) begin errors++; $display("FAIL os_start got busy=%b cnt=%0d want 1/5", busy[0], cnt(0)); end
    wait_exp(0, 100, n);
    checks++; if (n !== 60) begin errors++; $display("FAIL os_latency got %0d want 60", n); end
    checks++; if (busy[0] !== 1'b0 || cnt(0) !== 16'd0) begin errors++; $display("FAIL os_end got busy=%b cnt=%0d want 0/0", busy[0], cnt(0)); end
    cyc();
    checks++; if (expired[0] !== 1'b0) begin errors++; $display("FAIL os_pulse_width got %b want 0", expired[0]); end
  endtask
  task automatic test_periodic;
    int n;
    load_val[1*W +: W] = 16'd3;
    periodic[1] = 1'b1;
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    periodic[1] = 1'b0;
    wait_exp(1, 100, n);
    checks++; if (n < 25 || n > 36) begin errors++; $display("FAIL per_first got %0d want 25..36", n); end
    for (int p = 0; p < 10; p++) begin
      if (p == 2) load_val[1*W +: W] = 16'd7;
      wait_exp(1, 100, n);
      checks++; if (n !== 36) begin errors++; $display("FAIL per_period%0d got %0d want 36", p, n); end
      checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL per_busy%0d got %b want 1", p, busy[1]); end
    end
    stop[1] = 1'b1;
    cyc();
    stop[1] = 1'b0;
    checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL per_stop got %b want 0", busy[1]); end
  endtask
  task automatic test_stop;
    int n;
    logic seen;
    wait_tick(n);
    load_val[2*W +: W] = 16'd100;
    start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    for (int k = 0; k < 20; k++) wait_tick(n);
    checks++; if (cnt(2) !== 16'd80) begin errors++; $display("FAIL stop_pre got %0d want 80", cnt(2)); end
    stop[2] = 1'b1;
    cyc();
    stop[2] = 1'b0;
    checks++; if (busy[2] !== 1'b0 || cnt(2) !== 16'd0) begin errors++; $display("FAIL stop_state got busy=%b cnt=%0d want 0/0", busy[2], cnt(2)); end
    seen = expired[2];
    repeat (30) begin cyc(); seen |= expired[2]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stop_noexp got %b want 0", seen); end
    load_val[2*W +: W] = 16'd40;
    start[2] = 1'b1;
    stop[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    stop[2] = 1'b0;
    checks++; if (busy[2] !== 1'b1 || cnt(2) !== 16'd40) begin errors++; $display("FAIL start_stop got busy=%b cnt=%0d want 1/40", busy[2], cnt(2)); end
    stop[2] = 1'b1;
    cyc();
    stop[2] = 1'b0;
  endtask
  task automatic test_enable;
    int n;
    logic seen;
    wait_tick(n);
    load_val[0*W +: W] = 16'd2;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    cyc(5);
    en = 1'b0;
    seen = 1'b0;
    repeat (50) begin cyc(); seen |= tick_us | expired[0]; end
    en = 1'b1;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL en_frozen_pulse got %b want 0", seen); end
    checks++; if (cnt(0) !== 16'd2) begin errors++; $display("FAIL en_frozen_cnt got %0d want 2", cnt(0)); end
    wait_exp(0, 200, n);
    checks++; if (55 + n !== 73) begin errors++; $display("FAIL en_delay got %0d want 73", 55 + n); end
    load_val[0*W +: W] = 16'd10;
    load_val[1*W +: W] = 16'd10;
    periodic = 4'b0011;
    start = 4'b0011;
    cyc();
    start = '0;
    cyc(5);
    checks++; if (busy !== 4'b0011) begin errors++; $display("FAIL clr_pre_busy got %b want 0011", busy); end
    clear = 1'b1;
    load_val[3*W +: W] = 16'd10;
    start[3] = 1'b1;
    cyc();
    clear = 1'b0;
    start[3] = 1'b0;
    checks++; if (busy !== '0 || count !== '0) begin errors++; $display("FAIL clr_mid got busy=%b count=%h want 0/0", busy, count); end
  endtask
  task automatic test_multi;
    int n;
    for (int c = 0; c < CH; c++) load_val[c*W +: W] = 16'd2;
    periodic = '1;
    start = '1;
    cyc();
    start = '0;
    wait_exp(0, 100, n);
    checks++; if (expired !== 4'hF) begin errors++; $display("FAIL multi_exp got %b want 1111", expired); end
    cyc(30);
    reset = 1'b0;
    cyc();
    checks++; if ({tick_us, expired, busy} !== '0 || count !== '0) begin errors++; $display("FAIL mid_reset got t=%b e=%b b=%b c=%h want 0", tick_us, expired, busy, count); end
    reset = 1'b1;
    load_val[3*W +: W] = 16'd0;
    start[3] = 1'b1;
    cyc();
    start[3] = 1'b0;
    checks++; if (expired !== 4'b1000 || busy !== '0) begin errors++; $display("FAIL zero_load got e=%b b=%b want 1000/0000", expired, busy); end
    cyc();
    checks++; if (expired !== '0 || busy !== '0) begin errors++; $display("FAIL zero_after got e=%b b=%b want 0/0", expired, busy); end
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop();
    test_enable();
    test_multi();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
